// File: rtl/id_ex_if.sv
// id_ex_if: decode, forwarding and execute-side signals of the ID/EX stage.
interface id_ex_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
);
    logic                id_valid_i, id_ready_o;
    logic [XLEN-1:0]     id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]          id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic                id_rs1_used_i, id_rs2_used_i, id_src_a_pc_i, id_src_b_imm_i;
    logic [ALU_OP_W-1:0] id_alu_op_i;
    logic                id_rd_we_i, id_is_load_i;
    logic [4:0]          mem_rd_addr_i, wb_rd_addr_i;
    logic                mem_rd_we_i, wb_rd_we_i;
    logic [XLEN-1:0]     mem_result_i, wb_result_i;
    logic                ex_ready_i, flush_i;
    logic                ex_valid_o;
    logic [ALU_OP_W-1:0] ex_alu_op_o;
    logic [XLEN-1:0]     ex_operand_a_o, ex_operand_b_o, ex_rs2_data_o, ex_pc_o;
    logic [4:0]          ex_rd_addr_o;
    logic                ex_rd_we_o, ex_is_load_o, load_use_stall_o;

    modport master (
        output id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_alu_op_i, id_src_a_pc_i, id_src_b_imm_i,
               id_rd_addr_i, id_rd_we_i, id_is_load_i, mem_rd_addr_i, mem_rd_we_i, mem_result_i,
               wb_rd_addr_i, wb_rd_we_i, wb_result_i, ex_ready_i, flush_i,
        input  id_ready_o, ex_valid_o, ex_alu_op_o, ex_operand_a_o, ex_operand_b_o, ex_rs2_data_o,
               ex_pc_o, ex_rd_addr_o, ex_rd_we_o, ex_is_load_o, load_use_stall_o
    );

    modport slave (
        input  id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i, id_rs1_used_i, id_rs2_used_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_alu_op_i, id_src_a_pc_i, id_src_b_imm_i,
               id_rd_addr_i, id_rd_we_i, id_is_load_i, mem_rd_addr_i, mem_rd_we_i, mem_result_i,
               wb_rd_addr_i, wb_rd_we_i, wb_result_i, ex_ready_i, flush_i,
        output id_ready_o, ex_valid_o, ex_alu_op_o, ex_operand_a_o, ex_operand_b_o, ex_rs2_data_o,
               ex_pc_o, ex_rd_addr_o, ex_rd_we_o, ex_is_load_o, load_use_stall_o
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with MEM/WB operand forwarding and load-use bubbles.
module id_ex_stage #(
    parameter int                  XLEN       = 32,
    parameter int                  ALU_OP_W   = 4,
    parameter logic [ALU_OP_W-1:0] RST_ALU_OP = '0
) (
    input logic   clk_i,
    input logic   rst_i,
    id_ex_if.slave bus
);
    logic                valid, src_a_pc, src_b_imm, rd_we, is_load;
    logic [ALU_OP_W-1:0] alu_op;
    logic [XLEN-1:0]     pc, imm, rs1_data, rs2_data, fwd1, fwd2, cap1, cap2;
    logic [4:0]          rs1_addr, rs2_addr, rd_addr;
    logic                stall, ready, capture, advance;

    function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
        return we && dst != 5'd0 && dst == src;
    endfunction

    always_comb begin
        fwd1 = hit(bus.mem_rd_we_i, bus.mem_rd_addr_i, rs1_addr) ? bus.mem_result_i :
               hit(bus.wb_rd_we_i, bus.wb_rd_addr_i, rs1_addr) ? bus.wb_result_i : rs1_data;
        fwd2 = hit(bus.mem_rd_we_i, bus.mem_rd_addr_i, rs2_addr) ? bus.mem_result_i :
               hit(bus.wb_rd_we_i, bus.wb_rd_addr_i, rs2_addr) ? bus.wb_result_i : rs2_data;
        // the register file is written on the same edge we capture, so bypass its stale read
        cap1 = hit(bus.wb_rd_we_i, bus.wb_rd_addr_i, bus.id_rs1_addr_i) ? bus.wb_result_i : bus.id_rs1_data_i;
        cap2 = hit(bus.wb_rd_we_i, bus.wb_rd_addr_i, bus.id_rs2_addr_i) ? bus.wb_result_i : bus.id_rs2_data_i;
        stall = !rst_i && valid && is_load && rd_we && rd_addr != 5'd0 && bus.id_valid_i &&
                ((bus.id_rs1_used_i && bus.id_rs1_addr_i == rd_addr) ||
                 (bus.id_rs2_used_i && bus.id_rs2_addr_i == rd_addr));
        ready   = !rst_i && !bus.flush_i && (!valid || bus.ex_ready_i) && !stall;
        capture = bus.id_valid_i && ready;
        advance = valid && bus.ex_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid     <= 1'b0;
            alu_op    <= RST_ALU_OP;
            pc        <= '0;
            imm       <= '0;
            rs1_data  <= '0;
            rs2_data  <= '0;
            rs1_addr  <= '0;
            rs2_addr  <= '0;
            rd_addr   <= '0;
            src_a_pc  <= 1'b0;
            src_b_imm <= 1'b0;
            rd_we     <= 1'b0;
            is_load   <= 1'b0;
        end else if (bus.flush_i) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid     <= 1'b1;
            alu_op    <= bus.id_alu_op_i;
            pc        <= bus.id_pc_i;
            imm       <= bus.id_imm_i;
            rs1_data  <= cap1;
            rs2_data  <= cap2;
            rs1_addr  <= bus.id_rs1_addr_i;
            rs2_addr  <= bus.id_rs2_addr_i;
            rd_addr   <= bus.id_rd_addr_i;
            src_a_pc  <= bus.id_src_a_pc_i;
            src_b_imm <= bus.id_src_b_imm_i;
            rd_we     <= bus.id_rd_we_i;
            is_load   <= bus.id_is_load_i;
        end else if (advance) begin
            valid <= 1'b0;
        end else if (valid) begin
            // keep forwarded values once the producer leaves MEM/WB
            rs1_data <= fwd1;
            rs2_data <= fwd2;
        end
    end

    assign bus.id_ready_o       = ready;
    assign bus.load_use_stall_o = stall;
    assign bus.ex_valid_o       = valid;
    assign bus.ex_alu_op_o      = alu_op;
    assign bus.ex_operand_a_o   = src_a_pc ? pc : fwd1;
    assign bus.ex_operand_b_o   = src_b_imm ? imm : fwd2;
    assign bus.ex_rs2_data_o    = fwd2;
    assign bus.ex_pc_o          = pc;
    assign bus.ex_rd_addr_o     = rd_addr;
    assign bus.ex_rd_we_o       = rd_we;
    assign bus.ex_is_load_o     = is_load;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic against a slot-level reference model.
module tb_id_ex_stage;
    logic clk_i = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;

    id_ex_if #(.XLEN(32), .ALU_OP_W(4)) bus ();
    id_ex_stage #(.XLEN(32), .ALU_OP_W(4), .RST_ALU_OP(4'd0)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        v;
        logic [3:0]  op;
        logic [31:0] pc, imm, d1, d2;
        logic [4:0]  a1, a2, rd;
        logic        spc, simm, we, ld;
    } slot_t;

    slot_t m;

    function automatic logic [31:0] mfwd(input logic [4:0] a, input logic [31:0] d);
        if (bus.mem_rd_we_i && a != 0 && bus.mem_rd_addr_i == a) return bus.mem_result_i;
        if (bus.wb_rd_we_i && a != 0 && bus.wb_rd_addr_i == a) return bus.wb_result_i;
        return d;
    endfunction

    function automatic logic [31:0] mbyp(input logic [4:0] a, input logic [31:0] d);
        return (bus.wb_rd_we_i && a != 0 && bus.wb_rd_addr_i == a) ? bus.wb_result_i : d;
    endfunction

    function automatic logic mstall();
        return !rst_i && m.v && m.ld && m.we && m.rd != 0 && bus.id_valid_i &&
               ((bus.id_rs1_used_i && bus.id_rs1_addr_i == m.rd) || (bus.id_rs2_used_i && bus.id_rs2_addr_i == m.rd));
    endfunction

    function automatic logic mready();
        return !rst_i && !bus.flush_i && (!m.v || bus.ex_ready_i) && !mstall();
    endfunction

    always @(posedge clk_i) begin
        if (rst_i) m = '0;
        else if (bus.flush_i) m.v = 1'b0;
        else if (bus.id_valid_i && mready()) begin
            m.v = 1'b1;             m.op = bus.id_alu_op_i;   m.pc = bus.id_pc_i;
            m.imm = bus.id_imm_i;   m.a1 = bus.id_rs1_addr_i; m.a2 = bus.id_rs2_addr_i;
            m.d1 = mbyp(bus.id_rs1_addr_i, bus.id_rs1_data_i);
            m.d2 = mbyp(bus.id_rs2_addr_i, bus.id_rs2_data_i);
            m.rd = bus.id_rd_addr_i; m.spc = bus.id_src_a_pc_i; m.simm = bus.id_src_b_imm_i;
            m.we = bus.id_rd_we_i;   m.ld = bus.id_is_load_i;
        end else if (m.v && bus.ex_ready_i) m.v = 1'b0;
        else if (m.v) begin
            m.d1 = mfwd(m.a1, m.d1);
            m.d2 = mfwd(m.a2, m.d2);
        end
    end

    task automatic idle();
        bus.id_valid_i = 0; bus.id_pc_i = 0; bus.id_rs1_addr_i = 0; bus.id_rs2_addr_i = 0;
        bus.id_rs1_used_i = 0; bus.id_rs2_used_i = 0; bus.id_rs1_data_i = 0; bus.id_rs2_data_i = 0;
        bus.id_imm_i = 0; bus.id_alu_op_i = 0; bus.id_src_a_pc_i = 0; bus.id_src_b_imm_i = 0;
        bus.id_rd_addr_i = 0; bus.id_rd_we_i = 0; bus.id_is_load_i = 0;
        bus.mem_rd_addr_i = 0; bus.mem_rd_we_i = 0; bus.mem_result_i = 0;
        bus.wb_rd_addr_i = 0; bus.wb_rd_we_i = 0; bus.wb_result_i = 0;
        bus.ex_ready_i = 1; bus.flush_i = 0;
    endtask

    task automatic offer(input logic [4:0] a1, input logic [31:0] d1, input logic [4:0] a2,
                         input logic [31:0] d2, input logic [4:0] rd, input logic ld);
        bus.id_valid_i = 1; bus.id_pc_i = 32'h1000 + {27'd0, rd}; bus.id_alu_op_i = 4'd0;
        bus.id_rs1_addr_i = a1; bus.id_rs1_data_i = d1; bus.id_rs1_used_i = 1;
        bus.id_rs2_addr_i = a2; bus.id_rs2_data_i = d2; bus.id_rs2_used_i = 1;
        bus.id_rd_addr_i = rd; bus.id_rd_we_i = 1; bus.id_is_load_i = ld;
    endtask

    task automatic clear_slot();
        @(negedge clk_i); idle(); bus.flush_i = 1;
        @(negedge clk_i); bus.flush_i = 0;
    endtask

    task automatic test_reset();
        idle(); rst_i = 1; bus.id_valid_i = 1; bus.id_pc_i = 32'h40; bus.id_rs1_data_i = 32'h55;
        bus.id_imm_i = 32'h9; bus.id_alu_op_i = 4'd7;
        repeat (2) begin
            @(negedge clk_i); #1;
            checks++; if (bus.id_ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.id_ready_o); end
            checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.ex_valid_o); end
        end
        checks++; if (bus.ex_alu_op_o !== 4'd0) begin errors++; $display("FAIL reset_alu_op got %h want 0", bus.ex_alu_op_o); end
        checks++; if (bus.ex_operand_a_o !== 32'd0 || bus.ex_operand_b_o !== 32'd0) begin
            errors++; $display("FAIL reset_operands got %h/%h want 0/0", bus.ex_operand_a_o, bus.ex_operand_b_o); end
        checks++; if (bus.load_use_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", bus.load_use_stall_o); end
        @(negedge clk_i); rst_i = 0; #1;
        checks++; if (bus.id_ready_o !== 1'b1) begin errors++; $display("FAIL reset_first_ready got %b want 1", bus.id_ready_o); end
        @(negedge clk_i); #1;
        checks++; if (bus.ex_valid_o !== 1'b1 || bus.ex_pc_o !== 32'h40) begin
            errors++; $display("FAIL reset_first_accept got v=%b pc=%h want v=1 pc=40", bus.ex_valid_o, bus.ex_pc_o); end
        clear_slot();
    endtask

    task automatic test_mem_forward();
        offer(5'd1, 32'd5, 5'd2, 32'd9, 5'd3, 0); bus.ex_ready_i = 0;
        @(negedge clk_i); idle(); bus.ex_ready_i = 0;
        bus.mem_rd_addr_i = 5'd1; bus.mem_rd_we_i = 1; bus.mem_result_i = 32'h100; #1;
        checks++; if (bus.ex_operand_a_o !== 32'h100) begin errors++; $display("FAIL mem_fwd got %h want 100", bus.ex_operand_a_o); end
        checks++; if (bus.ex_operand_b_o !== 32'd9) begin errors++; $display("FAIL mem_fwd_b got %h want 9", bus.ex_operand_b_o); end
        bus.wb_rd_addr_i = 5'd1; bus.wb_rd_we_i = 1; bus.wb_result_i = 32'h200; #1;
        checks++; if (bus.ex_operand_a_o !== 32'h100) begin errors++; $display("FAIL mem_priority got %h want 100", bus.ex_operand_a_o); end
        bus.mem_rd_we_i = 0; #1;
        checks++; if (bus.ex_operand_a_o !== 32'h200) begin errors++; $display("FAIL wb_fwd got %h want 200", bus.ex_operand_a_o); end
        clear_slot();
    endtask

    task automatic test_x0_guard();
        offer(5'd0, 32'd0, 5'd0, 32'd0, 5'd4, 0); bus.ex_ready_i = 0;
        @(negedge clk_i); idle(); bus.ex_ready_i = 0;
        bus.mem_rd_addr_i = 5'd0; bus.mem_rd_we_i = 1; bus.mem_result_i = 32'hDEADBEEF;
        bus.wb_rd_addr_i = 5'd0; bus.wb_rd_we_i = 1; bus.wb_result_i = 32'hCAFEF00D; #1;
        checks++; if (bus.ex_operand_a_o !== 32'd0) begin errors++; $display("FAIL x0_guard got %h want 0", bus.ex_operand_a_o); end
        checks++; if (bus.ex_rs2_data_o !== 32'd0) begin errors++; $display("FAIL x0_guard_rs2 got %h want 0", bus.ex_rs2_data_o); end
        clear_slot();
    endtask

    task automatic test_load_use();
        offer(5'd1, 32'd0, 5'd2, 32'd0, 5'd5, 1);
        @(negedge clk_i); offer(5'd6, 32'd1, 5'd5, 32'd2, 5'd7, 0); #1;
        checks++; if (bus.load_use_stall_o !== 1'b1 || bus.id_ready_o !== 1'b0) begin
            errors++; $display("FAIL load_use got stall=%b ready=%b want 1/0", bus.load_use_stall_o, bus.id_ready_o); end
        @(negedge clk_i); #1;
        checks++; if (bus.ex_valid_o !== 1'b0 || bus.load_use_stall_o !== 1'b0 || bus.id_ready_o !== 1'b1) begin
            errors++; $display("FAIL load_use_bubble got v=%b stall=%b ready=%b want 0/0/1", bus.ex_valid_o, bus.load_use_stall_o, bus.id_ready_o); end
        @(negedge clk_i); idle(); #1;
        checks++; if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_addr_o !== 5'd7 || bus.ex_is_load_o !== 1'b0) begin
            errors++; $display("FAIL load_use_accept got v=%b rd=%0d ld=%b want 1/7/0", bus.ex_valid_o, bus.ex_rd_addr_o, bus.ex_is_load_o); end
        clear_slot();
    endtask

    task automatic test_stall_refresh();
        offer(5'd1, 32'd3, 5'd2, 32'h11, 5'd9, 0); bus.ex_ready_i = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i); idle(); bus.ex_ready_i = 0;
            if (c == 1) begin bus.wb_rd_addr_i = 5'd2; bus.wb_rd_we_i = 1; bus.wb_result_i = 32'h77; end
            #1;
            checks++; if (bus.ex_operand_b_o !== 32'h77) begin errors++; $display("FAIL refresh_c%0d got %h want 77", c, bus.ex_operand_b_o); end
            checks++; if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_addr_o !== 5'd9 || bus.ex_pc_o !== 32'h1009 || bus.ex_operand_a_o !== 32'd3) begin
                errors++; $display("FAIL refresh_fields_c%0d got v=%b rd=%0d pc=%h a=%h want 1/9/1009/3", c, bus.ex_valid_o, bus.ex_rd_addr_o, bus.ex_pc_o, bus.ex_operand_a_o); end
        end
        clear_slot();
    endtask

    task automatic test_flush();
        offer(5'd1, 32'd1, 5'd2, 32'd2, 5'd10, 0);
        @(negedge clk_i); offer(5'd3, 32'd3, 5'd4, 32'd4, 5'd11, 0); bus.ex_ready_i = 0; bus.flush_i = 1; #1;
        checks++; if (bus.id_ready_o !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", bus.id_ready_o); end
        @(negedge clk_i); idle(); bus.ex_ready_i = 0; #1;
        checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", bus.ex_valid_o); end
        @(negedge clk_i); #1;
        checks++; if (bus.ex_valid_o !== 1'b0) begin errors++; $display("FAIL flush_no_capture got %b want 0", bus.ex_valid_o); end
        idle();
    endtask

    task automatic test_random();
        logic [31:0] ea, eb, er;
        @(negedge clk_i); rst_i = 1; @(negedge clk_i); rst_i = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_i);
            rst_i = ($urandom_range(0, 99) == 0);
            bus.flush_i = ($urandom_range(0, 15) == 0);
            bus.ex_ready_i = ($urandom_range(0, 3) != 0);
            bus.id_valid_i = $urandom_range(0, 1);
            bus.id_pc_i = $urandom; bus.id_imm_i = $urandom; bus.id_alu_op_i = 4'($urandom);
            bus.id_rs1_addr_i = 5'($urandom_range(0, 7)); bus.id_rs2_addr_i = 5'($urandom_range(0, 7));
            bus.id_rs1_used_i = $urandom_range(0, 1); bus.id_rs2_used_i = $urandom_range(0, 1);
            bus.id_rs1_data_i = $urandom; bus.id_rs2_data_i = $urandom;
            bus.id_src_a_pc_i = $urandom_range(0, 1); bus.id_src_b_imm_i = $urandom_range(0, 1);
            bus.id_rd_addr_i = 5'($urandom_range(0, 7)); bus.id_rd_we_i = $urandom_range(0, 1);
            bus.id_is_load_i = $urandom_range(0, 1);
            bus.mem_rd_addr_i = 5'($urandom_range(0, 7)); bus.mem_rd_we_i = $urandom_range(0, 1); bus.mem_result_i = $urandom;
            bus.wb_rd_addr_i = 5'($urandom_range(0, 7)); bus.wb_rd_we_i = $urandom_range(0, 1); bus.wb_result_i = $urandom;
            #1;
            checks++; if (bus.ex_valid_o !== m.v) begin errors++; $display("FAIL rnd_valid i=%0d got %b want %b", i, bus.ex_valid_o, m.v); end
            checks++; if (bus.id_ready_o !== mready()) begin errors++; $display("FAIL rnd_ready i=%0d got %b want %b", i, bus.id_ready_o, mready()); end
            checks++; if (bus.load_use_stall_o !== mstall()) begin errors++; $display("FAIL rnd_stall i=%0d got %b want %b", i, bus.load_use_stall_o, mstall()); end
            if (m.v) begin
                ea = m.spc ? m.pc : mfwd(m.a1, m.d1);
                er = mfwd(m.a2, m.d2);
                eb = m.simm ? m.imm : er;
                checks++; if (bus.ex_operand_a_o !== ea || bus.ex_operand_b_o !== eb || bus.ex_rs2_data_o !== er) begin
                    errors++; $display("FAIL rnd_operands i=%0d got %h/%h/%h want %h/%h/%h", i, bus.ex_operand_a_o, bus.ex_operand_b_o, bus.ex_rs2_data_o, ea, eb, er); end
                checks++; if (bus.ex_alu_op_o !== m.op || bus.ex_pc_o !== m.pc || bus.ex_rd_addr_o !== m.rd || bus.ex_rd_we_o !== m.we || bus.ex_is_load_o !== m.ld) begin
                    errors++; $display("FAIL rnd_ctrl i=%0d got op=%h pc=%h rd=%0d we=%b ld=%b want op=%h pc=%h rd=%0d we=%b ld=%b", i,
                        bus.ex_alu_op_o, bus.ex_pc_o, bus.ex_rd_addr_o, bus.ex_rd_we_o, bus.ex_is_load_o, m.op, m.pc, m.rd, m.we, m.ld); end
            end
        end
        @(negedge clk_i); rst_i = 0; idle();
    endtask

    initial begin
        rst_i = 1; idle();
        test_reset();
        test_mem_forward();
        test_x0_guard();
        test_load_use();
        test_stall_refresh();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
